// File: rtl/alu_issue_ctrl_pkg.sv
// Shared execute-stage definitions: ALU funct3 encodings, word/adder types and the
// issue-sequencer state enum, exported so monitors can decode the sequencer state.
package alu_issue_ctrl_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      ADDER_ADD = 1'b0,
      ADDER_SUB = 1'b1
   } adderOp_t;

   localparam logic [2:0] FUNC_ADD  = 3'b000;
   localparam logic [2:0] FUNC_SLL  = 3'b001;
   localparam logic [2:0] FUNC_SLT  = 3'b010;
   localparam logic [2:0] FUNC_SLTU = 3'b011;
   localparam logic [2:0] FUNC_XOR  = 3'b100;
   localparam logic [2:0] FUNC_SR   = 3'b101;
   localparam logic [2:0] FUNC_OR   = 3'b110;
   localparam logic [2:0] FUNC_AND  = 3'b111;

   localparam logic [2:0] FUNC_BEQ  = 3'b000;
   localparam logic [2:0] FUNC_BNE  = 3'b001;
   localparam logic [2:0] FUNC_BLT  = 3'b100;
   localparam logic [2:0] FUNC_BGE  = 3'b101;
   localparam logic [2:0] FUNC_BLTU = 3'b110;
   localparam logic [2:0] FUNC_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } aluq_state_t;

   // Shifts run over several ALU cycles; their done flag is stale until the ALU loads.
   function automatic logic is_pure_shift(input logic branch, input logic [2:0] f3);
      return !branch && (f3 == FUNC_SLL || f3 == FUNC_SR);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer between decode and writeback: issues one op at a time to the
// multi-cycle ALU, waits for done (with a watchdog) and returns the result on a response port.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 40,
   parameter int RDW     = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [2:0]       req_f3,
   input  logic             req_arith,
   input  logic             req_branch,
   input  logic [RDW-1:0]   req_rd,
   output logic             alu_start,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_f3,
   output logic             alu_arith,
   output logic             alu_branch,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_done,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_taken,
   output logic [RDW-1:0]   rsp_rd,
   output logic             rsp_err,
   output logic [31:0]      busy_cycles,
   output aluq_state_t      dbg_state
);

   // Both ports use strict valid/ready: a transfer happens on a rising edge where valid
   // and ready are both high; a raised valid holds its payload until that transfer.
   aluq_state_t        state, state_nx;
   logic [7:0]         wd_cnt;
   logic [RDW-1:0]     rd_q;
   logic               req_fire, rsp_fire, done_ok, timeout;

   assign req_fire = req_valid && req_ready;
   assign rsp_fire = rsp_valid && rsp_ready;
   assign timeout  = (state == WAIT) && !alu_done && (wd_cnt == 8'(TIMEOUT - 1));
   assign dbg_state = state;

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      alu_start = 1'b0;
      rsp_valid = 1'b0;
      done_ok   = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = !flush;
            if (req_valid && !flush) state_nx = ISSUE;
         end
         ISSUE: begin
            alu_start = 1'b1;
            done_ok   = alu_done && !is_pure_shift(alu_branch, alu_f3);
            state_nx  = done_ok ? RESP : WAIT;
         end
         WAIT: begin
            done_ok = alu_done;
            if (alu_done || timeout) state_nx = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            req_ready = !flush && rsp_ready;
            if (rsp_ready) state_nx = (req_valid && !flush) ? ISSUE : IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Flush overrides done, timeout and both handshakes.
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_f3     <= '0;
         alu_arith  <= 1'b0;
         alu_branch <= 1'b0;
         rd_q       <= '0;
      end else if (req_fire) begin
         alu_a      <= req_a;
         alu_b      <= req_b;
         alu_f3     <= req_f3;
         alu_arith  <= req_arith;
         alu_branch <= req_branch;
         rd_q       <= req_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt      <= '0;
         busy_cycles <= '0;
      end else begin
         if (state == ISSUE)     wd_cnt <= '0;
         else if (state == WAIT) wd_cnt <= wd_cnt + 8'd1;
         if (state == ISSUE || state == WAIT) busy_cycles <= busy_cycles + 32'd1;
      end
   end

   // Response registers only change on completion, so they stay stable while stalled in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result <= '0;
         rsp_taken  <= 1'b0;
         rsp_rd     <= '0;
         rsp_err    <= 1'b0;
      end else if (!flush && done_ok) begin
         rsp_result <= alu_out;
         rsp_taken  <= alu_branch & alu_out[0];
         rsp_rd     <= rd_q;
         rsp_err    <= 1'b0;
      end else if (!flush && timeout) begin
         rsp_result <= '0;
         rsp_taken  <= 1'b0;
         rsp_rd     <= rd_q;
         rsp_err    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural multi-cycle ALU (iterative shifter, combinational
// everything else, optional stuck-done stub) and a queue-based response model.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 40;
   localparam int RDW     = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [WIDTH-1:0] req_a = '0;
   logic [WIDTH-1:0] req_b = '0;
   logic [2:0]       req_f3 = '0;
   logic             req_arith = 1'b0;
   logic             req_branch = 1'b0;
   logic [RDW-1:0]   req_rd = '0;
   logic             alu_start;
   logic [WIDTH-1:0] alu_a, alu_b;
   logic [2:0]       alu_f3;
   logic             alu_arith, alu_branch;
   logic [WIDTH-1:0] alu_out;
   logic             alu_done;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_taken;
   logic [RDW-1:0]   rsp_rd;
   logic             rsp_err;
   logic [31:0]      busy_cycles;
   aluq_state_t      dbg_state;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .RDW(RDW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_f3(req_f3), .req_arith(req_arith),
      .req_branch(req_branch), .req_rd(req_rd),
      .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_f3(alu_f3),
      .alu_arith(alu_arith), .alu_branch(alu_branch),
      .alu_out(alu_out), .alu_done(alu_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_taken(rsp_taken), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
      .busy_cycles(busy_cycles), .dbg_state(dbg_state)
   );

   // Architectural result of one op; branches put the outcome in bit 0.
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3, input logic arith,
                                           input logic branch);
      logic [4:0] sh;
      logic       t;
      sh = b[4:0];
      if (branch) begin
         case (f3)
            3'd0:    t = (a == b);
            3'd1:    t = (a != b);
            3'd4:    t = ($signed(a) < $signed(b));
            3'd5:    t = ($signed(a) >= $signed(b));
            3'd6:    t = (a < b);
            default: t = (a >= b);
         endcase
         return {31'd0, t};
      end
      case (f3)
         3'd0:    return arith ? a - b : a + b;
         3'd1:    return a << sh;
         3'd2:    return {31'd0, $signed(a) < $signed(b)};
         3'd3:    return {31'd0, a < b};
         3'd4:    return a ^ b;
         3'd5: begin
            if (arith) return $signed(a) >>> sh;
            return a >> sh;
         end
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   // ALU: shifts one bit per cycle after start; done is low while shifting or when stubbed.
   logic             stub_hold = 1'b0;
   logic [WIDTH-1:0] sh_val;
   logic [4:0]       shamt_left;
   logic             is_shift_op;

   assign is_shift_op = !alu_branch && (alu_f3 == FUNC_SLL || alu_f3 == FUNC_SR);
   assign alu_out  = is_shift_op ? sh_val : ref_alu(alu_a, alu_b, alu_f3, alu_arith, alu_branch);
   assign alu_done = !stub_hold && (shamt_left == 5'd0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_val     <= '0;
         shamt_left <= '0;
      end else if (alu_start) begin
         sh_val     <= alu_a;
         shamt_left <= is_shift_op ? alu_b[4:0] : 5'd0;
      end else if (shamt_left != 5'd0) begin
         shamt_left <= shamt_left - 5'd1;
         if (alu_f3 == FUNC_SLL) sh_val <= sh_val << 1;
         else if (alu_arith)     sh_val <= $signed(sh_val) >>> 1;
         else                    sh_val <= sh_val >> 1;
      end
   end

   // Scoreboard
   typedef struct {
      logic [31:0]    a;
      logic [31:0]    b;
      logic [2:0]     f3;
      logic [RDW-1:0] rd;
      logic [31:0]    res;
      logic           taken;
      logic           err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_busy = '0;
   int          total = 0;
   int          bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      total++;
      bad++;
      $display("FAIL %s: %s at %0t", name, what, $time);
   endtask

   function automatic exp_t make_exp();
      exp_t e;
      e.a     = req_a;
      e.b     = req_b;
      e.f3    = req_f3;
      e.rd    = req_rd;
      e.res   = stub_hold ? 32'd0 : ref_alu(req_a, req_b, req_f3, req_arith, req_branch);
      e.taken = !stub_hold && req_branch && e.res[0];
      e.err   = stub_hold;
      return e;
   endfunction

   // Compare every cycle, then advance the model to match the coming edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_busy = '0;
      end else begin
         check("busy_cycles", busy_cycles, exp_busy);
         check("req_ready", req_ready, !flush && (exp_q.size() == 0 || (rsp_valid && rsp_ready)));
         if (rsp_valid) begin
            if (exp_q.size() == 0) fail_now("rsp_unexpected", "rsp_valid=1 with no op outstanding");
            else begin
               check("rsp_result", rsp_result, exp_q[0].res);
               check("rsp_rd", rsp_rd, exp_q[0].rd);
               check("rsp_taken", rsp_taken, exp_q[0].taken);
               check("rsp_err", rsp_err, exp_q[0].err);
            end
         end
         if (exp_q.size() != 0) begin
            check("alu_a_held", alu_a, exp_q[0].a);
            check("alu_b_held", alu_b, exp_q[0].b);
            check("alu_f3_held", alu_f3, exp_q[0].f3);
         end
         if (exp_q.size() != 0 && !rsp_valid) exp_busy = exp_busy + 32'd1;
         if (flush) exp_q.delete();
         else begin
            if (rsp_valid && rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (req_valid && req_ready) exp_q.push_back(make_exp());
         end
      end
   end

   // Driver tasks: called and returning at posedge+1
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic arith, input logic branch, input logic [RDW-1:0] rd);
      req_valid = 1'b1; req_a = a; req_b = b; req_f3 = f3;
      req_arith = arith; req_branch = branch; req_rd = rd;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      if (!req_ready) fail_now("req_accept_timeout", "req_ready never rose");
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // Cycles from the accept edge to the first cycle with rsp_valid; returns at that negedge.
   task automatic wait_rsp(output int lat, output logic done_at_issue);
      lat = 0;
      done_at_issue = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (i == 1) done_at_issue = alu_done;
         if (rsp_valid) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) fail_now("rsp_timeout", "rsp_valid never rose");
   endtask

   initial begin
      #200000;
      fail_now("global_timeout", "simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int   lat;
      logic d1;

      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_alu_start", alu_start, 0);
      check("rst_busy", busy_cycles, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_alu_a", alu_a, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // ADD 5+7
      send(32'd5, 32'd7, FUNC_ADD, 1'b0, 1'b0, 5'd3);
      wait_rsp(lat, d1);
      check("add_lat", lat, 2);
      check("add_result", rsp_result, 12);
      check("add_rd", rsp_rd, 3);
      check("add_err", rsp_err, 0);
      @(posedge clk); #1;
      check("add_busy", busy_cycles, 1);

      // SLL 1 by 4: stale done in ISSUE must be ignored
      send(32'h1, 32'd4, FUNC_SLL, 1'b0, 1'b0, 5'd4);
      wait_rsp(lat, d1);
      check("sll_stale_done", d1, 1);
      check("sll_lat", lat, 7);
      check("sll_result", rsp_result, 32'h10);
      @(posedge clk); #1;
      check("sll_busy", busy_cycles, 7);

      // Branches
      send(32'd9, 32'd9, FUNC_BEQ, 1'b0, 1'b1, 5'd5);
      wait_rsp(lat, d1);
      check("beq_taken", rsp_taken, 1);
      @(posedge clk); #1;
      send(32'd5, 32'd3, FUNC_BLT, 1'b0, 1'b1, 5'd6);
      wait_rsp(lat, d1);
      check("blt_taken", rsp_taken, 0);
      @(posedge clk); #1;

      // Response stall then back-to-back
      rsp_ready = 1'b0;
      send(32'd100, 32'd23, FUNC_ADD, 1'b1, 1'b0, 5'd7);
      wait_rsp(lat, d1);
      check("b2b_lat", lat, 2);
      for (int i = 0; i < 3; i++) begin
         check("hold_valid", rsp_valid, 1);
         check("hold_result", rsp_result, 77);
         check("hold_req_ready", req_ready, 0);
         if (i < 2) @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      req_valid = 1'b1; req_a = 32'hF0F0; req_b = 32'h0FF0; req_f3 = FUNC_XOR;
      req_arith = 1'b0; req_branch = 1'b0; req_rd = 5'd9;
      @(negedge clk);
      check("b2b_req_ready", req_ready, 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("b2b_issue_start", alu_start, 1);
      check("b2b_issue_no_rsp", rsp_valid, 0);
      @(negedge clk);
      check("b2b_valid", rsp_valid, 1);
      check("b2b_result", rsp_result, 32'hFF00);
      check("b2b_rd", rsp_rd, 9);
      @(posedge clk); #1;

      // Flush during WAIT of SRA by 20
      send(32'h8000_0000, 32'd20, FUNC_SR, 1'b1, 1'b0, 5'd10);
      repeat (2) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_idle_ready", req_ready, 1);
      check("flush_no_start", alu_start, 0);
      for (int i = 0; i < 5; i++) begin
         check("flush_no_rsp", rsp_valid, 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      send(32'd1000, 32'd24, FUNC_ADD, 1'b0, 1'b0, 5'd11);
      wait_rsp(lat, d1);
      check("post_flush_result", rsp_result, 1024);
      @(posedge clk); #1;

      // Watchdog with stuck done
      stub_hold = 1'b1;
      send(32'd2, 32'd2, FUNC_ADD, 1'b0, 1'b0, 5'd12);
      wait_rsp(lat, d1);
      check("wd_lat", lat, 42);
      check("wd_err", rsp_err, 1);
      check("wd_result", rsp_result, 0);
      check("wd_rd", rsp_rd, 12);
      @(posedge clk); #1;

      // Asynchronous reset mid-WAIT
      send(32'd3, 32'd3, FUNC_ADD, 1'b0, 1'b0, 5'd13);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_start", alu_start, 0);
      check("mid_rst_busy", busy_cycles, 0);
      check("mid_rst_alu_a", alu_a, 0);
      check("mid_rst_err", rsp_err, 0);
      check("mid_rst_rd", rsp_rd, 0);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      stub_hold = 1'b0;
      @(posedge clk); #1;
      send(32'd20, 32'd22, FUNC_ADD, 1'b0, 1'b0, 5'd14);
      wait_rsp(lat, d1);
      check("post_rst_lat", lat, 2);
      check("post_rst_result", rsp_result, 42);
      @(posedge clk); #1;
      check("post_rst_busy", busy_cycles, 1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
